i2c_target: RTL
===============

# i2c_target

I2C target (responder) that answers the team's I2C master on the same bus. It decodes START/STOP, matches a 7-bit device address, and accepts register-address and data bytes into an internal register file. It returns register contents on reads, supporting both current-address and repeated-start combined reads. It samples the open-drain SCL/SDA lines with a fast local clock and drives SDA only by pulling low.

## Interface
- DEV_ADDR, 7'h08: 7-bit target address matched against the first byte after START.
- DEPTH, 16: register-file depth in bytes; power of two, 2..256. AW = log2(DEPTH).
- clk, input, 1: local clock. Must be ≥ 8× the SCL bit rate.
- rst_n, input, 1: reset. One clock; reset is synchronous and active-low.
- scl_i, input, 1: bus SCL (asynchronous).
- sda_i, input, 1: bus SDA (asynchronous).
- sda_o, output, 1: SDA drive. 0 pulls the line low; 1 releases it.
- wr_strobe, output, 1: one-clk pulse per completed, ACKed write-data byte.
- wr_addr, output, AW: register index written. Valid with wr_strobe.
- wr_data, output, 8: byte written. Valid with wr_strobe.
- busy, output, 1: high from an addressed START until STOP or return to IDLE.

## Operation
- scl_i and sda_i pass through 2-flop synchronizers. Edge detection runs on the synced values.
- START is SDA falling while SCL is high. STOP is SDA rising while SCL is high. Either is recognised in any state.
- Data bits are sampled on SCL rising. sda_o changes only on the clk after SCL falling is detected.
- Bytes are MSB first. Each byte is followed by a 9th (ACK) bit.
- States:
  - IDLE: sda_o=1; waits for START.
  - DEVADDR: shifts 8 bits. If bits[7:1] == DEV_ADDR, go to DEVACK and latch rw=bit0. Otherwise release SDA and go to IDLE; no response until the next START.
  - DEVACK: drives 0 for the 9th bit. Then go to REGADDR if rw=0, or RDDATA if rw=1.
  - REGADDR: shifts 8 bits. The pointer loads from byte[AW-1:0]; upper bits are ignored. Then REGACK drives 0 and goes to WRDATA.
  - WRDATA: shifts 8 bits and writes reg[ptr]. Pulses wr_strobe with wr_addr=ptr. Then ptr=ptr+1 mod DEPTH. WRACK drives 0, then returns to WRDATA.
  - RDDATA: loads reg[ptr] on the SCL falling edge that ends the preceding ACK. Shifts the byte out on sda_o, then ptr=ptr+1 mod DEPTH. On the 9th bit, SDA is released and the master's ACK is sampled. ACK (0) reloads and stays in RDDATA. NACK (1) goes to WAITSTOP, which leaves SDA released until STOP or START.
- Repeated START in any state: abort the current byte with no strobe and no pointer change, then enter DEVADDR. The pointer is kept, so a write-pointer followed by Sr + read reads from that pointer.
- STOP in any state: go to IDLE, sda_o=1, busy=0. A partial byte is discarded.
- General call (address 0) and 10-bit addressing are NACKed unless they match DEV_ADDR.

## Timing
- Reset values: sda_o=1, wr_strobe=0, wr_addr=0, wr_data=0, busy=0, ptr=0, all registers 0x00, state IDLE.
- Reset mid-transfer: the block is in IDLE with sda_o=1 on the clk after rst_n is sampled low. Bus activity until the next START is ignored.
- Condition/edge detect latency is 3 clk from the pin change (2 sync + 1 edge).
- ACK drive runs from the SCL falling edge that ends bit 8 (+3 clk) to the SCL falling edge that ends bit 9 (+3 clk).
- wr_strobe asserts for exactly one clk, 1 clk after the 8th data-bit rising edge is detected. The register file updates on the same clk.
- Read data bit n is valid on sda_o within 4 clk of SCL falling and is held until the next SCL falling.
- Pointer wrap: ptr=DEPTH-1 increments to 0 on both write and read.
- A START and STOP cannot coincide; if SDA toggles with SCL high mid-byte, it is treated as the corresponding condition.

## Test plan
- Write: START, 0x10, 0x92, 0xAC, STOP. Expect three ACKs (sda_o=0 on each 9th bit), one wr_strobe with wr_addr=2 and wr_data=0xAC, and busy low after STOP.
- Combined read: START, 0x10, 0x02, Sr, 0x11, then read 1 byte with master NACK, then STOP. Expect the bus byte to be 0xAC, SDA released on the 9th bit, and final ptr=3.
- Address mismatch: START, 0x14, 0x55, STOP. Expect sda_o=1 for every SCL cycle, no wr_strobe, and busy=0.
- Wrap: START, 0x10, 0x0F, 0x11, 0x22, STOP. Expect reg[15]=0x11 and reg[0]=0x22, with wr_addr sequence 15 then 0. A following current-address read returns reg[1]=0x00.
- Aborts: STOP after 4 data bits gives no strobe, sda_o=1, IDLE. A separate case asserts rst_n low mid-read with sda_o=0 driving; expect sda_o=1 on the next clk and the registers cleared.

Source files
------------

// File: rtl/i2c_target.sv
// rtl/i2c_target.sv - I2C target with 7-bit address match and byte register file
`timescale 1ns/1ps
module i2c_target #(
    parameter logic [6:0] DEV_ADDR = 7'h08,
    parameter int         DEPTH    = 16,
    localparam int        AW       = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          scl_i,
    input  logic          sda_i,
    output logic          sda_o,
    output logic          wr_strobe,
    output logic [AW-1:0] wr_addr,
    output logic [7:0]    wr_data,
    output logic          busy
);

    localparam logic [3:0] S_IDLE     = 4'd0;
    localparam logic [3:0] S_DEVADDR  = 4'd1;
    localparam logic [3:0] S_DEVACK   = 4'd2;
    localparam logic [3:0] S_REGADDR  = 4'd3;
    localparam logic [3:0] S_REGACK   = 4'd4;
    localparam logic [3:0] S_WRDATA   = 4'd5;
    localparam logic [3:0] S_WRACK    = 4'd6;
    localparam logic [3:0] S_RDDATA   = 4'd7;
    localparam logic [3:0] S_RDACK    = 4'd8;
    localparam logic [3:0] S_WAITSTOP = 4'd9;

    logic          scl_s1, scl_s2, scl_d;
    logic          sda_s1, sda_s2, sda_d;
    logic [3:0]    state;
    logic [3:0]    bit_cnt;
    logic [7:0]    shreg;
    logic [AW-1:0] ptr;
    logic          rw;
    logic [7:0]    regs [DEPTH];

    logic       scl_rise, scl_fall, start_det, stop_det, rx_done;
    logic [7:0] rx_byte;

    assign scl_rise  = scl_s2 & ~scl_d;
    assign scl_fall  = ~scl_s2 & scl_d;
    assign start_det = scl_s2 & scl_d & sda_d & ~sda_s2;
    assign stop_det  = scl_s2 & scl_d & ~sda_d & sda_s2;
    assign rx_byte   = {shreg[6:0], sda_s2};
    assign rx_done   = scl_rise && (bit_cnt == 4'd7);

    // In ACK states sda_o itself marks the phase: released = waiting for the
    // fall that ends bit 8, driven = waiting for the fall that ends bit 9.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            scl_s1    <= 1'b1;
            scl_s2    <= 1'b1;
            scl_d     <= 1'b1;
            sda_s1    <= 1'b1;
            sda_s2    <= 1'b1;
            sda_d     <= 1'b1;
            state     <= S_IDLE;
            bit_cnt   <= 4'd0;
            shreg     <= 8'h00;
            ptr       <= '0;
            rw        <= 1'b0;
            sda_o     <= 1'b1;
            wr_strobe <= 1'b0;
            wr_addr   <= '0;
            wr_data   <= 8'h00;
            busy      <= 1'b0;
            for (int i = 0; i < DEPTH; i++) regs[i] <= 8'h00;
        end else begin
            scl_s1    <= scl_i;
            scl_s2    <= scl_s1;
            scl_d     <= scl_s2;
            sda_s1    <= sda_i;
            sda_s2    <= sda_s1;
            sda_d     <= sda_s2;
            wr_strobe <= 1'b0;
            if (stop_det) begin
                state <= S_IDLE;
                sda_o <= 1'b1;
                busy  <= 1'b0;
            end else if (start_det) begin
                state   <= S_DEVADDR;
                bit_cnt <= 4'd0;
                sda_o   <= 1'b1;
            end else begin
                case (state)
                    S_DEVADDR: if (scl_rise) begin
                        shreg   <= rx_byte;
                        bit_cnt <= bit_cnt + 4'd1;
                        if (rx_done) begin
                            if (rx_byte[7:1] == DEV_ADDR) begin
                                rw    <= rx_byte[0];
                                busy  <= 1'b1;
                                state <= S_DEVACK;
                            end else begin
                                busy  <= 1'b0;
                                state <= S_IDLE;
                            end
                        end
                    end
                    S_REGADDR: if (scl_rise) begin
                        shreg   <= rx_byte;
                        bit_cnt <= bit_cnt + 4'd1;
                        if (rx_done) begin
                            ptr   <= rx_byte[AW-1:0];
                            state <= S_REGACK;
                        end
                    end
                    S_WRDATA: if (scl_rise) begin
                        shreg   <= rx_byte;
                        bit_cnt <= bit_cnt + 4'd1;
                        if (rx_done) begin
                            regs[ptr] <= rx_byte;
                            wr_strobe <= 1'b1;
                            wr_addr   <= ptr;
                            wr_data   <= rx_byte;
                            ptr       <= ptr + AW'(1);
                            state     <= S_WRACK;
                        end
                    end
                    S_DEVACK: if (scl_fall) begin
                        if (sda_o) begin
                            sda_o <= 1'b0;
                        end else begin
                            bit_cnt <= 4'd0;
                            if (rw) begin
                                shreg <= regs[ptr];
                                sda_o <= regs[ptr][7];
                                state <= S_RDDATA;
                            end else begin
                                sda_o <= 1'b1;
                                state <= S_REGADDR;
                            end
                        end
                    end
                    S_REGACK, S_WRACK: if (scl_fall) begin
                        if (sda_o) begin
                            sda_o <= 1'b0;
                        end else begin
                            sda_o   <= 1'b1;
                            bit_cnt <= 4'd0;
                            state   <= S_WRDATA;
                        end
                    end
                    S_RDDATA: begin
                        if (scl_rise) begin
                            bit_cnt <= bit_cnt + 4'd1;
                        end else if (scl_fall) begin
                            if (bit_cnt == 4'd8) begin
                                sda_o <= 1'b1;
                                ptr   <= ptr + AW'(1);
                                state <= S_RDACK;
                            end else begin
                                shreg <= {shreg[6:0], 1'b0};
                                sda_o <= shreg[6];
                            end
                        end
                    end
                    S_RDACK: begin
                        if (scl_rise && sda_s2) begin
                            state <= S_WAITSTOP;
                        end else if (scl_fall) begin
                            bit_cnt <= 4'd0;
                            shreg   <= regs[ptr];
                            sda_o   <= regs[ptr][7];
                            state   <= S_RDDATA;
                        end
                    end
                    default: sda_o <= 1'b1;
                endcase
            end
        end
    end

endmodule
